mem_island_rsp_buffer: RTL
==========================

Name: mem_island_rsp_buffer

Overview:
- Per-port adapter directly upstream of one narrow or wide request port of the memory island core.
- The core returns read data a fixed number of cycles after a grant and cannot stall responses. This block gives the requester a response channel with a p_ready backpressure handshake.
- Credit counting throttles requests so every response already in flight always has a free FIFO slot.
- One instance per requester port; instantiated in the island top before the core.

Parameters:
- AddrWidth, 32, byte address width.
- DataWidth, 64, data width (narrow or wide port); strobe width DataWidth/8.
- Depth, 4, response FIFO entries, equal to the maximum outstanding transactions; power of 2, ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- up_q_valid_i  in  1  requester request valid
- up_q_ready_o  out  1  request accepted
- up_q_addr_i  in  AddrWidth  byte address
- up_q_write_i  in  1  1=write
- up_q_data_i  in  DataWidth  write data
- up_q_strb_i  in  DataWidth/8  byte enables
- up_p_valid_o  out  1  response valid to requester
- up_p_ready_i  in  1  requester accepts response
- up_p_data_o  out  DataWidth  read data (don't-care for writes)
- mem_q_valid_o  out  1  request to core port
- mem_q_ready_i  in  1  core grant
- mem_q_addr_o, mem_q_write_o, mem_q_data_o, mem_q_strb_o  out  as upstream  forwarded request fields
- mem_p_valid_i  in  1  core response valid (no backpressure)
- mem_p_data_i  in  DataWidth  core response data
- idle_o  out  1  no transaction outstanding or buffered

Behaviour:
- Credit counter cnt, width $clog2(Depth+1), holds in-flight plus buffered responses. Reset value 0.
- Gating signal: room = (cnt < Depth).
- Request path is combinational with no added latency:
  - mem_q_valid_o = up_q_valid_i & room.
  - up_q_ready_o = mem_q_ready_i & room.
  - Request fields pass straight through.
  - mem_q_valid_o never depends on mem_q_ready_i.
- A grant is mem_q_valid_o & mem_q_ready_i. A pop is up_p_valid_o & up_p_ready_i.
- Counter update:
  - grant only: cnt+1.
  - pop only: cnt−1.
  - grant and pop in the same cycle: cnt unchanged.
  - At cnt==Depth with a same-cycle pop, room is still 0 in that cycle; the request is accepted the next cycle.
- The core returns exactly one mem_p_valid_i per grant, for reads and writes alike, in grant order.
- Response FIFO:
  - Circular buffer with write and read pointers of $clog2(Depth) bits plus a wrap bit; both pointers reset to 0.
  - mem_p_valid_i writes mem_p_data_i at the write pointer, then the write pointer increments.
  - A pop increments the read pointer.
  - Pointers wrap modulo Depth. full = pointers equal with wrap bits different; empty = pointers fully equal.
- up_p_valid_o = !empty, so the base latency from mem_p_valid_i to up_p_valid_o is 1 cycle.
- up_p_data_o = entry at the read pointer; it is held stable while up_p_valid_o=1 and up_p_ready_i=0.
- Simultaneous push and pop on a non-empty FIFO: both take effect and occupancy is unchanged.
- Overflow cannot happen because of the credit scheme. mem_p_valid_i while full is a protocol error: simulation assertion, data dropped, pointers unchanged.
- mem_p_valid_i while cnt==0 is a protocol error: assertion, ignored.
- idle_o = (cnt==0).
- Reset values: up_p_valid_o=0, idle_o=1, up_q_ready_o=0 and mem_q_valid_o=0 unless the corresponding inputs are asserted (room=1 after reset).
- Reset mid-operation:
  - All state clears immediately and asynchronously; buffered responses are lost.
  - The core shares rst_ni, so its in-flight responses are flushed too.
- FIFO storage needs no reset. Only pointers and cnt are reset.

Optional Feature:
- Macro: MEM_ISLAND_RSP_FALLTHROUGH_EN.
- Defined:
  - When the FIFO is empty and mem_p_valid_i=1, up_p_valid_o=1 in the same cycle with up_p_data_o=mem_p_data_i (0-cycle latency).
  - If up_p_ready_i=1 in that cycle, the entry is not written and cnt decrements.
  - If up_p_ready_i=0, the entry is written and presented from the FIFO the next cycle.
- Undefined: registered behaviour as above, fixed 1-cycle added latency, no combinational path from mem_p_* to up_p_*.

Test Plan:
- Single read, core latency 1, up_p_ready_i=1, addr 0x40, data 0xDEAD_BEEF → up_p_valid_o at grant+2 (grant+1 with macro), data 0xDEAD_BEEF, idle_o back to 1 after the pop.
- Depth=4, up_p_ready_i=0, 6 back-to-back reads → exactly 4 grants, then up_q_ready_o=0 and mem_q_valid_o=0. Raise ready → 4 responses pop in order, and the 5th and 6th requests are granted.
- Full credits (cnt=4) with a pop and a pending request in the same cycle → no grant that cycle, grant next cycle, cnt returns to 4.
- 10 mixed writes and reads with random up_p_ready_i → exactly 10 responses in order; read data matches previously written values; pointers wrap twice without loss.
- Assert rst_ni low with 3 responses buffered → up_p_valid_o=0 and idle_o=1 immediately. After release, a new read completes normally.
- Inject mem_p_valid_i with cnt==0 → assertion fires, no response is produced, and the pointers do not move.

Source files
------------

// File: rtl/mem_island_rsp_buffer.sv
// rtl/mem_island_rsp_buffer.sv - credit-throttled response FIFO in front of one memory island core port
// Optional feature macro: MEM_ISLAND_RSP_FALLTHROUGH_EN (zero-latency bypass when the FIFO is empty)
module mem_island_rsp_buffer #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   up_q_valid_i,
  output logic                   up_q_ready_o,
  input  logic [AddrWidth-1:0]   up_q_addr_i,
  input  logic                   up_q_write_i,
  input  logic [DataWidth-1:0]   up_q_data_i,
  input  logic [DataWidth/8-1:0] up_q_strb_i,
  output logic                   up_p_valid_o,
  input  logic                   up_p_ready_i,
  output logic [DataWidth-1:0]   up_p_data_o,
  output logic                   mem_q_valid_o,
  input  logic                   mem_q_ready_i,
  output logic [AddrWidth-1:0]   mem_q_addr_o,
  output logic                   mem_q_write_o,
  output logic [DataWidth-1:0]   mem_q_data_o,
  output logic [DataWidth/8-1:0] mem_q_strb_o,
  input  logic                   mem_p_valid_i,
  input  logic [DataWidth-1:0]   mem_p_data_i,
  output logic                   idle_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [CntW-1:0] CntMax = CntW'(Depth);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW:0]   PtrOne = (PtrW + 1)'(1);

  logic [CntW-1:0]      r_cnt;
  logic [PtrW:0]        r_wptr;
  logic [PtrW:0]        r_rptr;
  logic [DataWidth-1:0] r_mem [Depth];

  logic w_room, w_grant, w_pop, w_empty, w_full;
  logic w_push_ok, w_wr_en, w_rd_en;

  // Credits cover every in-flight and buffered response, so the FIFO can never overflow.
  assign w_room        = (r_cnt < CntMax);
  assign mem_q_valid_o = up_q_valid_i & w_room;
  assign up_q_ready_o  = mem_q_ready_i & w_room;
  assign mem_q_addr_o  = up_q_addr_i;
  assign mem_q_write_o = up_q_write_i;
  assign mem_q_data_o  = up_q_data_i;
  assign mem_q_strb_o  = up_q_strb_i;
  assign w_grant       = mem_q_valid_o & mem_q_ready_i;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PtrW] != r_rptr[PtrW]) && (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
  assign w_push_ok = mem_p_valid_i & ~w_full & (r_cnt != '0);
  assign w_rd_en   = ~w_empty & up_p_ready_i;

`ifdef MEM_ISLAND_RSP_FALLTHROUGH_EN
  assign up_p_valid_o = ~w_empty | w_push_ok;
  assign up_p_data_o  = w_empty ? mem_p_data_i : r_mem[r_rptr[PtrW-1:0]];
  assign w_wr_en      = w_push_ok & ~(w_empty & up_p_ready_i);
`else
  assign up_p_valid_o = ~w_empty;
  assign up_p_data_o  = r_mem[r_rptr[PtrW-1:0]];
  assign w_wr_en      = w_push_ok;
`endif

  assign w_pop  = up_p_valid_o & up_p_ready_i;
  assign idle_o = (r_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_grant && !w_pop) begin
        r_cnt <= r_cnt + CntOne;
      end else if (!w_grant && w_pop) begin
        r_cnt <= r_cnt - CntOne;
      end
      if (w_wr_en) begin
        r_wptr <= r_wptr + PtrOne;
      end
      if (w_rd_en) begin
        r_rptr <= r_rptr + PtrOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wptr[PtrW-1:0]] <= mem_p_data_i;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(mem_p_valid_i && r_cnt == '0))
        else $warning("mem_island_rsp_buffer: core response with no outstanding credit, ignored");
      assert (!(mem_p_valid_i && w_full))
        else $warning("mem_island_rsp_buffer: core response while FIFO full, dropped");
    end
  end
`endif

endmodule
